// File: rtl/bus_decoder.sv
// bus_decoder: registered address decoder and interconnect between one bus
// master and NSLAVES memory-mapped slaves. Each slave owns a base/mask window,
// the lowest matching index wins, and unmatched requests go to an optional
// default slave or get an error response. The selected slave is waited on
// with a timeout. All master and slave outputs come straight from flops.
module bus_decoder #(
  parameter int                    NSLAVES       = 4,
  parameter int                    AW            = 16,
  parameter int                    DW            = 8,
  parameter logic [NSLAVES*AW-1:0] BASE          = {16'hfa10, 16'hfa00, 16'h0000, 16'h0000},
  parameter logic [NSLAVES*AW-1:0] MASK          = {16'hfff0, 16'hfff0, 16'h0000, 16'h0000},
  parameter int                    DEFAULT_SLAVE = NSLAVES,
  parameter int                    TIMEOUT       = 15,
  parameter logic [DW-1:0]         ERR_DATA      = 8'hff
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [AW-1:0]         i_addr,
  input  logic [DW-1:0]         i_dat,
  output logic [DW-1:0]         o_dat,
  input  logic                  i_cs,
  input  logic                  i_we,
  output logic                  o_ack,
  output logic                  o_err,
  output logic [NSLAVES-1:0]    o_slave_cs,
  output logic                  o_slave_we,
  output logic [AW-1:0]         o_slave_addr,
  output logic [DW-1:0]         o_slave_dat,
  input  logic [NSLAVES*DW-1:0] i_slave_dat,
  input  logic [NSLAVES-1:0]    i_slave_ack
);

  localparam int             SW        = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam bit             DEF_VALID = (DEFAULT_SLAVE < NSLAVES);
  localparam logic [SW-1:0]  DEF_IDX   = SW'(DEFAULT_SLAVE);
  localparam logic [7:0]     TO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACTIVE   = 3'd1,
    RESP_OK  = 3'd2,
    RESP_ERR = 3'd3,
    HOLD     = 3'd4
  } state_t;

  // One-hot select vector for a slave index.
  function automatic logic [NSLAVES-1:0] onehot(input logic [SW-1:0] idx);
    logic [NSLAVES-1:0] v;
    v = {NSLAVES{1'b0}};
    for (int k = 0; k < NSLAVES; k++) begin
      v[k] = (idx == SW'(k));
    end
    return v;
  endfunction

  // Window test for slave k against an address.
  function automatic logic win_match(input logic [AW-1:0] a, input int k);
    return ((a & MASK[k*AW +: AW]) == (BASE[k*AW +: AW] & MASK[k*AW +: AW]));
  endfunction

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [SW-1:0]        sel_q, sel_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [DW-1:0]        dat_q, dat_d;
  logic [NSLAVES-1:0]   scs_q, scs_d;
  logic                 swe_q, swe_d;
  logic [AW-1:0]        saddr_q, saddr_d;
  logic [DW-1:0]        sdat_q, sdat_d;

  logic                 dec_hit_s;
  logic [SW-1:0]        dec_idx_s;
  logic                 dec_valid_s;
  logic [SW-1:0]        dec_sel_s;
  logic                 sel_ack_s;
  logic [DW-1:0]        sel_dat_s;

  // Priority address decode: scanning downwards leaves the lowest match.
  always_comb begin
    dec_hit_s = 1'b0;
    dec_idx_s = {SW{1'b0}};
    for (int k = NSLAVES - 1; k >= 0; k--) begin
      dec_hit_s = win_match(i_addr, k) ? 1'b1 : dec_hit_s;
      dec_idx_s = win_match(i_addr, k) ? SW'(k) : dec_idx_s;
    end
    dec_valid_s = dec_hit_s | DEF_VALID;
    dec_sel_s   = dec_hit_s ? dec_idx_s : DEF_IDX;
  end

  // Ack and read data of the latched slave only; other acks are ignored.
  always_comb begin
    sel_ack_s = i_slave_ack[sel_q];
    sel_dat_s = i_slave_dat[sel_q*DW +: DW];
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    scs_d   = scs_q;
    swe_d   = swe_q;
    saddr_d = saddr_q;
    sdat_d  = sdat_q;
    case (state_q)
      IDLE: begin
        if (i_cs && dec_valid_s) begin
          sel_d   = dec_sel_s;
          swe_d   = i_we;
          saddr_d = i_addr;
          sdat_d  = i_dat;
          cnt_d   = 8'd0;
          scs_d   = onehot(dec_sel_s);
          state_d = ACTIVE;
        end else if (i_cs) begin
          err_d   = 1'b1;
          dat_d   = ERR_DATA;
          state_d = RESP_ERR;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (sel_ack_s) begin
          ack_d   = 1'b1;
          dat_d   = sel_dat_s;
          scs_d   = {NSLAVES{1'b0}};
          state_d = RESP_OK;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          dat_d   = ERR_DATA;
          scs_d   = {NSLAVES{1'b0}};
          state_d = RESP_ERR;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      RESP_OK:  state_d = HOLD;
      RESP_ERR: state_d = HOLD;
      HOLD: begin
        // A request still held high after the response must not restart.
        if (!i_cs) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        scs_d   = {NSLAVES{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= {SW{1'b0}};
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= {DW{1'b0}};
      scs_q   <= {NSLAVES{1'b0}};
      swe_q   <= 1'b0;
      saddr_q <= {AW{1'b0}};
      sdat_q  <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      scs_q   <= scs_d;
      swe_q   <= swe_d;
      saddr_q <= saddr_d;
      sdat_q  <= sdat_d;
    end
  end

  assign o_dat        = dat_q;
  assign o_ack        = ack_q;
  assign o_err        = err_q;
  assign o_slave_cs   = scs_q;
  assign o_slave_we   = swe_q;
  assign o_slave_addr = saddr_q;
  assign o_slave_dat  = sdat_q;

endmodule
